// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - control sequencer for a shift-add multiplier
// Drives load/add/shift strobes to an external result register and adder.
module mult_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a_in,
   input  logic             i_lsb,
   input  logic             i_done_ack,
   output logic             o_load_mul,
   output logic             o_do_add,
   output logic             o_do_shift,
   output logic [WIDTH-1:0] o_a_out,
   output logic             o_busy,
   output logic             o_done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a_out;
   logic             r_load_mul;
   logic             r_add_phase;
   logic             r_do_shift;
   logic             r_busy;
   logic             r_done;
   logic [CW-1:0]    w_cnt_inc;

   assign w_cnt_inc = r_cnt + 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_a_out     <= '0;
         r_load_mul  <= 1'b0;
         r_add_phase <= 1'b0;
         r_do_shift  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_LOAD;
                  r_a_out    <= i_a_in;
                  r_cnt      <= '0;
                  r_load_mul <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            S_LOAD: begin
               r_state     <= S_ADD;
               r_load_mul  <= 1'b0;
               r_add_phase <= 1'b1;
            end
            S_ADD: begin
               r_state     <= S_SHIFT;
               r_add_phase <= 1'b0;
               r_do_shift  <= 1'b1;
            end
            S_SHIFT: begin
               r_do_shift <= 1'b0;
               // Counter saturates at WIDTH so a stray extra SHIFT can never wrap it
               if (r_cnt != C_LAST) begin
                  r_cnt <= w_cnt_inc;
               end
               if (w_cnt_inc == C_LAST || r_cnt == C_LAST) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state     <= S_ADD;
                  r_add_phase <= 1'b1;
               end
            end
            S_DONE: begin
               // A start arriving with the ack is dropped; IDLE must be visited first
               if (i_done_ack) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_load_mul  <= 1'b0;
               r_add_phase <= 1'b0;
               r_do_shift  <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign o_load_mul = r_load_mul;
   assign o_do_add   = r_add_phase & i_lsb;
   assign o_do_shift = r_do_shift;
   assign o_a_out    = r_a_out;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - directed bench for mult_sequencer with attached shift-add datapath
module tb_mult_sequencer;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [W-1:0]   a_in;
   logic           lsb;
   logic           done_ack;
   logic           load_mul;
   logic           do_add;
   logic           do_shift;
   logic [W-1:0]   a_out;
   logic           busy;
   logic           done;

   logic [W-1:0]   b_val;
   logic [2*W:0]   r_res;
   int             n_load, n_add, n_shift, n_both;
   int             checks = 0;
   int             errors = 0;
   int             lat;
   int             seen;

   always #5 clk = ~clk;

   mult_sequencer #(.WIDTH(W)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_start    (start),
      .i_a_in     (a_in),
      .i_lsb      (lsb),
      .i_done_ack (done_ack),
      .o_load_mul (load_mul),
      .o_do_add   (do_add),
      .o_do_shift (do_shift),
      .o_a_out    (a_out),
      .o_busy     (busy),
      .o_done     (done)
   );

   // Result register and adder: {carry, hi, lo}, multiplier starts in lo
   assign lsb = r_res[0];

   always @(posedge clk) begin
      if (load_mul) begin
         r_res <= {{(W+1){1'b0}}, b_val};
      end else if (do_add) begin
         r_res[2*W:W] <= {1'b0, r_res[2*W-1:W]} + {1'b0, a_out};
      end else if (do_shift) begin
         r_res <= r_res >> 1;
      end
      if (load_mul) n_load++;
      if (do_add) n_add++;
      if (do_shift) n_shift++;
      if (do_add && do_shift) n_both++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      n_load  = 0;
      n_add   = 0;
      n_shift = 0;
      n_both  = 0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 100) begin
         tick();
         cycles++;
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [15:0] exp_prod, input int exp_adds);
      b_val = b;
      clear_counts();
      a_in  = a;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_load"}, load_mul, 1);
      chk({tag, "_aout"}, a_out, a);
      wait_done(lat);
      chk({tag, "_latency"}, lat, 17);
      chk({tag, "_product"}, r_res[2*W-1:0], exp_prod);
      chk({tag, "_adds"}, n_add, exp_adds);
      chk({tag, "_shifts"}, n_shift, W);
      chk({tag, "_loads"}, n_load, 1);
      chk({tag, "_overlap"}, n_both, 0);
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      chk({tag, "_idle"}, {busy, done}, 0);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      a_in     = '0;
      done_ack = 1'b0;
      b_val    = '0;
      r_res    = '0;
      clear_counts();
      tick();
      tick();
      chk("rst_outputs", {load_mul, do_add, do_shift, busy, done}, 0);
      chk("rst_aout", a_out, 0);
      reset = 1'b0;

      run_op("op5x3", 8'd5, 8'd3, 16'd15, 2);
      run_op("op255x255", 8'd255, 8'd255, 16'd65025, 8);
      run_op("op0xAA", 8'd0, 8'hAA, 16'd0, 4);
      run_op("op7x0", 8'd7, 8'd0, 16'd0, 0);

      // start held high throughout; a_in changes mid-operation
      b_val = 8'd4;
      clear_counts();
      a_in  = 8'd3;
      start = 1'b1;
      tick();
      a_in = 8'd9;
      wait_done(lat);
      chk("hold_latency", lat, 17);
      chk("hold_loads", n_load, 1);
      chk("hold_aout", a_out, 3);
      chk("hold_product", r_res[2*W-1:0], 12);
      for (int i = 0; i < 10; i++) tick();
      chk("noack_done_busy", {done, busy}, 2'b11);
      chk("noack_loads", n_load, 1);
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      chk("ack_start_idle", {busy, done, load_mul}, 0);
      tick();
      chk("b2b_load", {load_mul, busy}, 2'b11);
      chk("b2b_aout", a_out, 9);
      start = 1'b0;

      // reset during the third SHIFT
      seen = 0;
      lat  = 0;
      while (seen < 3 && lat < 100) begin
         tick();
         lat++;
         if (do_shift) seen++;
      end
      chk("third_shift_seen", seen, 3);
      reset = 1'b1;
      tick();
      chk("midrst_outputs", {load_mul, do_add, do_shift, busy, done}, 0);
      chk("midrst_aout", a_out, 0);
      reset = 1'b0;

      run_op("op6x7", 8'd6, 8'd7, 16'd42, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; bit counter sized ceil(log2(WIDTH+1)).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  multiplicand; captured on accepted start.
REQ-006 LSB  input  1  current multiplier LSB from the result shift register.
REQ-007 done_ack  input  1  consumer acknowledge of a completed product.
REQ-008 Load_mul  output  1  one-cycle strobe that loads the multiplier into the result register.
REQ-009 do_add  output  1  request that the result register latch an add for the current bit.
REQ-010 do_shift  output  1  one-cycle strobe that shifts the result register.
REQ-011 a_out  output  WIDTH  registered multiplicand driven to the adder.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  product valid; high only in DONE.

Function
REQ-014 States SHALL be IDLE, LOAD, ADD, SHIFT, DONE; outputs are Moore (decoded from state), except do_add = LSB in ADD.
REQ-015 IDLE: start=1 SHALL capture a_in into a_out, clear the bit counter, and go to LOAD next cycle; start=0 stays in IDLE.
REQ-016 LOAD SHALL assert Load_mul for exactly one cycle, then go to ADD.
REQ-017 ADD SHALL drive do_add = LSB, with do_shift=0, for one cycle, then go to SHIFT.
REQ-018 SHIFT SHALL assert do_shift=1, with do_add=0, for one cycle and increment the bit counter.
REQ-019 From SHIFT, a post-increment counter < WIDTH SHALL return to ADD; counter == WIDTH SHALL go to DONE.
REQ-020 Exactly WIDTH ADD/SHIFT pairs SHALL occur per multiply; do_add and do_shift are never high in the same cycle.
REQ-021 Latency: start accepted at edge N -> Load_mul during cycle N+1 -> done first high in cycle N+2+2*WIDTH (cycle N+18 for WIDTH=8).
REQ-022 DONE SHALL hold done=1 until done_ack=1, then go to IDLE on the next edge; done is never a single-cycle pulse unless ack is already high.
REQ-023 start SHALL be ignored in every state other than IDLE; a_out is not changed while busy.
REQ-024 start=1 in the first IDLE cycle after DONE SHALL be accepted normally; back-to-back operations need no idle gap beyond that one cycle.
REQ-025 Simultaneous start and done_ack in DONE: the ack SHALL be honoured and the start SHALL be dropped.
REQ-026 The bit counter SHALL NOT wrap: it saturates at WIDTH and is cleared only on accept or reset.

Reset
REQ-027 reset=1 at a clock edge SHALL force the following regardless of state, including mid-operation: state=IDLE, counter=0, a_out=0, Load_mul=do_add=do_shift=busy=done=0.
REQ-028 When reset is deasserted, the block SHALL accept start on the very next edge.

Verification
REQ-029 With the result register and the adder attached: a_in=5, multiplier b=3, start pulse -> done at start+18 cycles, product=15, exactly two do_add cycles.
REQ-030 a_in=255, b=255 -> product=65025; a_in=0, b=0xAA -> product=0; b=0 -> do_add is never high.
REQ-031 Hold start=1 for the whole operation -> a single multiply only; Load_mul pulses once; the next operation is accepted only after DONE->IDLE.
REQ-032 Hold done_ack=0 for 10 cycles in DONE -> done stays high and busy=1; ack with start=1 in the same cycle -> IDLE, no new Load_mul.
REQ-033 Assert reset in the 3rd SHIFT -> next cycle all outputs are 0 and state is IDLE; a new start then gives the correct product.
REQ-034 Assertions: do_add&do_shift never both high; Load_mul is one cycle per accept; the do_shift count between Load_mul and done equals WIDTH.
